// File: rtl/id_ex_ctrl_pkg.sv
// Shared decode vocabulary for the ID/EX stage and the ALU. This covers ALU op codes,
// MIPS opcode/funct constants, the operand-select enums and the control bundle.
package id_ex_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_SRL = 4'd2,
      ALU_OR  = 4'd3,
      ALU_AND = 4'd4,
      ALU_NOR = 4'd5,
      ALU_SLT = 4'd6,
      ALU_XOR = 4'd7,
      ALU_SLL = 4'd8,
      ALU_SRA = 4'd9
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // B operand source; the immediate variants carry the extend mode
   typedef enum logic [1:0] {
      B_RT       = 2'd0,
      B_IMM_SEXT = 2'd1,
      B_IMM_ZEXT = 2'd2
   } b_sel_e;

   typedef enum logic [1:0] {
      DEST_NONE = 2'd0,
      DEST_RD   = 2'd1,
      DEST_RT   = 2'd2
   } dest_sel_e;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
   } ctrl_t;

   typedef struct packed {
      alu_op_e   alu_op;
      logic      a_shamt;
      b_sel_e    b_sel;
      dest_sel_e dest_sel;
      ctrl_t     ctrl;
      logic      known;
      logic      bubble;
   } dec_t;

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS decode: opcode/funct -> ALU op, operand selects, controls.
// Latency: none (pure combinational). Backpressure: none, the stall is handled by the caller.
module id_decode
   import id_ex_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec        = '0;
      dec.alu_op = ALU_ADD;
      dec.b_sel  = B_RT;
      dec.known  = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            dec.dest_sel       = DEST_RD;
            dec.ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
               FN_AND:          dec.alu_op = ALU_AND;
               FN_OR:           dec.alu_op = ALU_OR;
               FN_XOR:          dec.alu_op = ALU_XOR;
               FN_NOR:          dec.alu_op = ALU_NOR;
               FN_SLT:          dec.alu_op = ALU_SLT;
               FN_SLL:  begin dec.alu_op = ALU_SLL; dec.a_shamt = 1'b1; end
               FN_SRL:  begin dec.alu_op = ALU_SRL; dec.a_shamt = 1'b1; end
               FN_SRA:  begin dec.alu_op = ALU_SRA; dec.a_shamt = 1'b1; end
               FN_SLLV:         dec.alu_op = ALU_SLL;
               FN_SRLV:         dec.alu_op = ALU_SRL;
               FN_SRAV:         dec.alu_op = ALU_SRA;
               // jr already redirected fetch in ID; nothing left for EX to do
               FN_JR: begin
                  dec.bubble   = 1'b1;
                  dec.ctrl     = '0;
                  dec.dest_sel = DEST_NONE;
               end
               default: begin
                  dec.known    = 1'b0;
                  dec.ctrl     = '0;
                  dec.dest_sel = DEST_NONE;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec.b_sel          = B_IMM_SEXT;
            dec.dest_sel       = DEST_RT;
            dec.ctrl.reg_write = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            dec.alu_op         = (opcode == OP_ANDI) ? ALU_AND :
                                 (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            dec.b_sel          = B_IMM_ZEXT;
            dec.dest_sel       = DEST_RT;
            dec.ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            dec.b_sel           = B_IMM_SEXT;
            dec.dest_sel        = DEST_RT;
            dec.ctrl.reg_write  = 1'b1;
            dec.ctrl.mem_read   = 1'b1;
            dec.ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            dec.b_sel          = B_IMM_SEXT;
            dec.dest_sel       = DEST_RT;
            dec.ctrl.mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec.alu_op      = ALU_SUB;
            dec.ctrl.branch = 1'b1;
         end
         default: dec.known = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX register: decodes instr_D, then registers the operands and controls for the ALU. Latency is 1 cycle.
// Flush > stall > load. A stall holds all state. Optional illegal trap: ID_ILLEGAL_TRAP_EN.
module id_ex_ctrl
   import id_ex_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        instr_D,
   input  logic               valid_D,
   input  logic [DATA_W-1:0]  rs_data_D,
   input  logic [DATA_W-1:0]  rt_data_D,
   input  logic               stall,
   input  logic               flush,
   output logic [DATA_W-1:0]  reg_A_E,
   output logic [DATA_W-1:0]  reg_B_E,
   output logic [3:0]         alu_op_E,
   output logic [5:0]         opcode_E,
   output logic [DATA_W-1:0]  rt_data_E,
   output logic [RADDR_W-1:0] dest_reg_E,
   output logic               reg_write_E,
   output logic               mem_read_E,
   output logic               mem_write_E,
   output logic               mem_to_reg_E,
   output logic               branch_E,
   output logic               valid_E
`ifdef ID_ILLEGAL_TRAP_EN
   ,
   output logic               illegal_o,
   output logic [31:0]        illegal_instr_o
`endif
);

   dec_t dec;

   id_decode u_decode (
      .opcode (instr_D[31:26]),
      .funct  (instr_D[5:0]),
      .dec    (dec)
   );

   // rs arrives already read from the register file
   logic unused_rs_field;
   assign unused_rs_field = ^instr_D[25:21];

   logic [DATA_W-1:0]  a_dec, b_dec;
   logic [RADDR_W-1:0] dest_dec;
   logic               trap_unknown;

   logic [DATA_W-1:0]  a_d, a_q, b_d, b_q, rt_d, rt_q;
   logic [3:0]         alu_op_d, alu_op_q;
   logic [5:0]         opcode_d, opcode_q;
   logic [RADDR_W-1:0] dest_d, dest_q;
   ctrl_t              ctrl_d, ctrl_q;
   logic               valid_d, valid_q;

   always_comb begin
      a_dec = dec.a_shamt ? DATA_W'(instr_D[10:6]) : rs_data_D;
      case (dec.b_sel)
         B_IMM_SEXT: b_dec = DATA_W'($signed(instr_D[15:0]));
         B_IMM_ZEXT: b_dec = DATA_W'(instr_D[15:0]);
         default:    b_dec = rt_data_D;
      endcase
      case (dec.dest_sel)
         DEST_RD: dest_dec = RADDR_W'(instr_D[15:11]);
         DEST_RT: dest_dec = RADDR_W'(instr_D[20:16]);
         default: dest_dec = '0;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      rt_d     = rt_q;
      alu_op_d = alu_op_q;
      opcode_d = opcode_q;
      dest_d   = dest_q;
      ctrl_d   = ctrl_q;
      valid_d  = valid_q;
      if (flush || (!stall && (!valid_D || dec.bubble || trap_unknown))) begin
         a_d      = '0;
         b_d      = '0;
         rt_d     = '0;
         alu_op_d = ALU_ADD;
         opcode_d = '0;
         dest_d   = '0;
         ctrl_d   = '0;
         valid_d  = 1'b0;
      end else if (!stall) begin
         a_d              = a_dec;
         b_d              = b_dec;
         rt_d             = rt_data_D;
         alu_op_d         = dec.alu_op;
         opcode_d         = instr_D[31:26];
         dest_d           = dest_dec;
         ctrl_d           = dec.ctrl;
         // $0 is hardwired, so a write to it is dropped here rather than in WB
         ctrl_d.reg_write = dec.ctrl.reg_write && (dest_dec != '0);
         valid_d          = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         rt_q     <= '0;
         alu_op_q <= '0;
         opcode_q <= '0;
         dest_q   <= '0;
         ctrl_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         rt_q     <= rt_d;
         alu_op_q <= alu_op_d;
         opcode_q <= opcode_d;
         dest_q   <= dest_d;
         ctrl_q   <= ctrl_d;
         valid_q  <= valid_d;
      end
   end

`ifdef ID_ILLEGAL_TRAP_EN
   logic        illegal_d, illegal_q;
   logic [31:0] illegal_instr_d, illegal_instr_q;

   assign trap_unknown = valid_D && !dec.known;

   // Only the first encoding is captured; the flag is sticky until reset
   always_comb begin
      illegal_d       = illegal_q;
      illegal_instr_d = illegal_instr_q;
      if (!flush && !stall && trap_unknown && !illegal_q) begin
         illegal_d       = 1'b1;
         illegal_instr_d = instr_D;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q       <= 1'b0;
         illegal_instr_q <= '0;
      end else begin
         illegal_q       <= illegal_d;
         illegal_instr_q <= illegal_instr_d;
      end
   end

   assign illegal_o       = illegal_q;
   assign illegal_instr_o = illegal_instr_q;
`else
   logic unused_known;
   assign unused_known = dec.known;
   assign trap_unknown = 1'b0;
`endif

   assign reg_A_E      = a_q;
   assign reg_B_E      = b_q;
   assign rt_data_E    = rt_q;
   assign alu_op_E     = alu_op_q;
   assign opcode_E     = opcode_q;
   assign dest_reg_E   = dest_q;
   assign reg_write_E  = ctrl_q.reg_write;
   assign mem_read_E   = ctrl_q.mem_read;
   assign mem_write_E  = ctrl_q.mem_write;
   assign mem_to_reg_E = ctrl_q.mem_to_reg;
   assign branch_E     = ctrl_q.branch;
   assign valid_E      = valid_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Scoreboarded bench for id_ex_ctrl: directed cases, then random traffic checked against a reference model.
module tb_id_ex_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr_D = '0;
   logic        valid_D = 1'b0;
   logic [31:0] rs_data_D = '0;
   logic [31:0] rt_data_D = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] reg_A_E, reg_B_E, rt_data_E;
   logic [3:0]  alu_op_E;
   logic [5:0]  opcode_E;
   logic [4:0]  dest_reg_E;
   logic        reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E, branch_E, valid_E;
`ifdef ID_ILLEGAL_TRAP_EN
   logic        illegal_o;
   logic [31:0] illegal_instr_o;
`endif

   always #5 clk = ~clk;

   id_ex_ctrl #(.DATA_W(32), .RADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .valid_D(valid_D),
      .rs_data_D(rs_data_D), .rt_data_D(rt_data_D), .stall(stall), .flush(flush),
      .reg_A_E(reg_A_E), .reg_B_E(reg_B_E), .alu_op_E(alu_op_E), .opcode_E(opcode_E),
      .rt_data_E(rt_data_E), .dest_reg_E(dest_reg_E), .reg_write_E(reg_write_E),
      .mem_read_E(mem_read_E), .mem_write_E(mem_write_E), .mem_to_reg_E(mem_to_reg_E),
      .branch_E(branch_E), .valid_E(valid_E)
`ifdef ID_ILLEGAL_TRAP_EN
      , .illegal_o(illegal_o), .illegal_instr_o(illegal_instr_o)
`endif
   );

   typedef struct {
      logic [31:0] a, b, rt, ill_instr;
      logic [3:0]  op;
      logic [5:0]  opc;
      logic [4:0]  dest;
      logic        rw, mr, mw, m2r, br, v, chk, unk, ill;
   } exp_t;

   exp_t        expq[$];
   exp_t        cur;
   exp_t        mon_e;
   logic        ill = 1'b0;
   logic [31:0] ill_instr = '0;
   int          n_chk = 0;
   int          n_fail = 0;

   logic [5:0] fn_tab [0:17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3F, 6'h01};
   logic [5:0] op_tab [0:10] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05,
                                 6'h3F, 6'h10};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t bubble();
      exp_t e;
      e = '{default: 0};
      e.chk = 1'b1;
      return e;
   endfunction

   // Reference decode: one row per instruction class, values built arithmetically
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      logic [5:0]  op, fn;
      logic [31:0] sext, zext, shamt;
      op    = ins[31:26];
      fn    = ins[5:0];
      sext  = {{16{ins[15]}}, ins[15:0]};
      zext  = {16'd0, ins[15:0]};
      shamt = {27'd0, ins[10:6]};
      e = '{default: 0};
      e.v = 1; e.chk = 1; e.opc = op; e.a = rs; e.b = rt; e.rt = rt;
      case (op)
         6'h00: begin
            e.dest = ins[15:11]; e.rw = 1;
            case (fn)
               6'h20, 6'h21: e.op = 0;
               6'h22, 6'h23: e.op = 1;
               6'h24: e.op = 4;
               6'h25: e.op = 3;
               6'h26: e.op = 7;
               6'h27: e.op = 5;
               6'h2A: e.op = 6;
               6'h00: begin e.op = 8; e.a = shamt; end
               6'h02: begin e.op = 2; e.a = shamt; end
               6'h03: begin e.op = 9; e.a = shamt; end
               6'h04: e.op = 8;
               6'h06: e.op = 2;
               6'h07: e.op = 9;
               6'h08: e = bubble();
               default: begin e.dest = 0; e.rw = 0; e.unk = 1; e.chk = 0; end
            endcase
         end
         6'h08, 6'h09: begin e.b = sext; e.dest = ins[20:16]; e.rw = 1; end
         6'h0C: begin e.op = 4; e.b = zext; e.dest = ins[20:16]; e.rw = 1; end
         6'h0D: begin e.op = 3; e.b = zext; e.dest = ins[20:16]; e.rw = 1; end
         6'h0E: begin e.op = 7; e.b = zext; e.dest = ins[20:16]; e.rw = 1; end
         6'h23: begin e.b = sext; e.dest = ins[20:16]; e.rw = 1; e.mr = 1; e.m2r = 1; end
         6'h2B: begin e.b = sext; e.dest = ins[20:16]; e.mw = 1; end
         6'h04, 6'h05: begin e.op = 1; e.br = 1; end
         default: begin e.unk = 1; e.chk = 0; end
      endcase
      if (e.dest == 0) e.rw = 0;
      return e;
   endfunction

   // Drive one cycle of inputs, advance the model, post the expectation after the edge
   task automatic issue(input logic [31:0] ins, input logic v, input logic [31:0] rs,
                        input logic [31:0] rt, input logic st, input logic fl);
      exp_t e;
      instr_D = ins; valid_D = v; rs_data_D = rs; rt_data_D = rt; stall = st; flush = fl;
      if (fl) cur = bubble();
      else if (!st) begin
         e = v ? model(ins, rs, rt) : bubble();
`ifdef ID_ILLEGAL_TRAP_EN
         if (v && e.unk) begin
            if (!ill) begin ill = 1; ill_instr = ins; end
            e = bubble();
         end
`endif
         cur = e;
      end
      cur.ill = ill;
      cur.ill_instr = ill_instr;
      @(posedge clk);
      expq.push_back(cur);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(valid_E), 0);
      check({tag, "_alu_op"}, 32'(alu_op_E), 0);
      check({tag, "_opcode"}, 32'(opcode_E), 0);
      check({tag, "_A"}, reg_A_E, 0);
      check({tag, "_B"}, reg_B_E, 0);
      check({tag, "_rt_data"}, rt_data_E, 0);
      check({tag, "_dest"}, 32'(dest_reg_E), 0);
      check({tag, "_ctrl"}, 32'({reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E, branch_E}), 0);
`ifdef ID_ILLEGAL_TRAP_EN
      check({tag, "_illegal"}, 32'(illegal_o), 0);
      check({tag, "_illegal_instr"}, illegal_instr_o, 0);
`endif
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         check("valid_E", 32'(valid_E), 32'(mon_e.v));
         check("alu_op_E", 32'(alu_op_E), 32'(mon_e.op));
         check("opcode_E", 32'(opcode_E), 32'(mon_e.opc));
         check("ctrl_E(rw,mr,mw,m2r,br)",
               32'({reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E, branch_E}),
               32'({mon_e.rw, mon_e.mr, mon_e.mw, mon_e.m2r, mon_e.br}));
         if (mon_e.chk) begin
            check("reg_A_E", reg_A_E, mon_e.a);
            check("reg_B_E", reg_B_E, mon_e.b);
            check("rt_data_E", rt_data_E, mon_e.rt);
            check("dest_reg_E", 32'(dest_reg_E), 32'(mon_e.dest));
         end
`ifdef ID_ILLEGAL_TRAP_EN
         check("illegal_o", 32'(illegal_o), 32'(mon_e.ill));
         check("illegal_instr_o", illegal_instr_o, mon_e.ill_instr);
`endif
      end
   end

   function automatic logic alu_zero();
      logic z;
      z = (reg_A_E - reg_B_E) == 32'd0;
      return (opcode_E == 6'h05) ? !z : z;
   endfunction

   initial begin
      logic [31:0] r;
      cur = bubble();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      issue(32'h00221820, 1, 32'd5, 32'd7, 0, 0);            // add $3,$1,$2
      issue(32'h000220C0, 1, 32'h99, 32'h11, 0, 0);          // sll $4,$2,3
      issue(32'h00222007, 1, 32'h24, 32'h55, 0, 0);          // srav $4,$2,$1
      issue(32'h2005FFFF, 1, 32'd0, 32'd0, 0, 0);            // addi $5,$0,-1
      issue(32'h3005FFFF, 1, 32'd0, 32'd0, 0, 0);            // andi $5,$0,0xFFFF
      issue(32'h8C26FFFC, 1, 32'h100, 32'h3, 0, 0);          // lw $6,-4($1)
      issue(32'hAC250008, 1, 32'h200, 32'hDEAD, 0, 0);       // sw $5,8($1)
      issue(32'h14220003, 1, 32'd9, 32'd9, 0, 0);            // bne, equal operands
      check("bne_zero_equal", 32'(alu_zero()), 0);
      issue(32'h14220003, 1, 32'd9, 32'd3, 0, 0);            // bne, unequal operands
      check("bne_zero_unequal", 32'(alu_zero()), 1);
      issue(32'h00221822, 1, 32'd40, 32'd2, 0, 0);           // sub, then hold it
      issue(32'h00221825, 1, 32'd1, 32'd1, 1, 0);
      issue(32'h2005FFFF, 1, 32'd3, 32'd4, 1, 0);
      issue(32'h00221820, 1, 32'd5, 32'd7, 1, 1);            // flush wins over stall
      issue(32'h00220020, 1, 32'd5, 32'd7, 0, 0);            // add $0
      issue(32'h03E00008, 1, 32'd5, 32'd7, 0, 0);            // jr $31
      issue(32'h0022183F, 1, 32'd5, 32'd7, 0, 0);            // unknown funct
      issue(32'hFC000000, 1, 32'd5, 32'd7, 0, 0);            // unknown opcode
      issue(32'h40000000, 1, 32'd5, 32'd7, 0, 0);            // second unknown
      issue(32'h00221820, 0, 32'd5, 32'd7, 0, 0);            // valid_D low

      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            r[31:26] = 6'h00;
            r[5:0]   = fn_tab[$urandom_range(0, 17)];
         end else begin
            r[31:26] = op_tab[$urandom_range(0, 10)];
         end
         issue(r, $urandom_range(0, 9) != 0, $urandom, $urandom,
               $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      end

      issue(32'h00221820, 1, 32'd11, 32'd12, 0, 0);
      issue(32'h2005FFFF, 1, 32'd1, 32'd2, 1, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("reset_mid_stall");
      cur = bubble();
      ill = 1'b0;
      ill_instr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'h00221820, 1, 32'd21, 32'd22, 0, 0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(expq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_ctrl.md
Name: id_ex_ctrl

Overview:
- Producer end of the execute-stage ALU interface: decodes the MIPS instruction held in IF/ID into the 4-bit ALU operation code and operand selection, and registers them with the pipeline controls into the ID/EX register.
- Drives reg_A_E, reg_B_E, alu_op_E and opcode_E straight into the ALU, so the ALU can resolve BNE by inverting zero.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, operand/datapath width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_D  in  32  instruction from IF/ID.
- valid_D  in  1  instr_D holds a real instruction.
- rs_data_D  in  DATA_W  register-file read of rs.
- rt_data_D  in  DATA_W  register-file read of rt.
- stall  in  1  hold ID/EX contents.
- flush  in  1  replace next ID/EX contents with a bubble.
- reg_A_E  out  DATA_W  ALU operand A.
- reg_B_E  out  DATA_W  ALU operand B.
- alu_op_E  out  4  ALU op code.
- opcode_E  out  6  instr[31:26] passed through.
- rt_data_E  out  DATA_W  store data for SW.
- dest_reg_E  out  RADDR_W  write-back register.
- reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E, branch_E  out  1 each  stage controls.
- valid_E  out  1  ID/EX holds a real instruction.

Behaviour:
- Reset is asynchronous on rst_n low. Every output is 0, which is a bubble: alu_op ADD, no writes.
- Latency is 1 cycle. Decode is combinational from instr_D and is captured on the clk edge.
- Priority per edge is flush > stall > load.
  - Flush loads a bubble: all controls 0, valid_E 0, and datapath outputs 0.
  - Stall holds every register.
  - Flush and stall asserted together give a bubble.
- valid_D=0 loads a bubble.
- ALU codes: ADD 0, SUB 1, SRL 2, OR 3, AND 4, NOR 5, SLT 6, XOR 7, SLL 8, SRA 9.
- R-type (opcode 0), decoded by funct:
  - add/addu 20/21 → ADD; sub/subu 22/23 → SUB.
  - and 24, or 25, xor 26, nor 27, slt 2A → the matching code.
  - For all of these: A = rs, B = rt, dest = rd, reg_write = 1.
- Shifts: the ALU computes B shifted by A, so B = rt always.
  - sll 00, srl 02, sra 03 use A = zero-extended shamt, instr[10:6].
  - sllv 04, srlv 06, srav 07 use A = rs, and only A[4:0] is significant.
- jr (funct 08) decodes to a bubble with branch_E 0; jumps are resolved in ID.
- I-type: A = rs, dest = rt.
  - addi 08 and addiu 09 use a sign-extended immediate, op ADD.
  - andi 0C, ori 0D and xori 0E use a zero-extended immediate with the matching op.
  - lw 23: ADD with sign-extended immediate, mem_read = mem_to_reg = reg_write = 1.
  - sw 2B: ADD with sign-extended immediate, mem_write = 1, reg_write = 0.
- beq 04 and bne 05: op SUB, A = rs, B = rt, branch_E = 1, no writes.
- Any write with dest 0 forces reg_write_E = 0.
- Unknown opcode or funct: valid_E = 1, all controls 0, alu_op ADD.
- Reset asserted mid-stall clears immediately. After release, the first edge loads normally.

Optional Feature:
- Macro ID_ILLEGAL_TRAP_EN.
- Defined: adds outputs illegal_o (1 bit, sticky) and illegal_instr_o (32 bit).
  - The first unknown encoding loaded while valid sets illegal_o and captures the instruction.
  - That load becomes a bubble with valid_E = 0.
  - Both outputs clear only on reset.
  - Flushed or stalled instructions never trap.
- Undefined: the ports are absent and unknown encodings behave as described in Behaviour.

Decomposition:
- Shared package holds:
  - ALU op codes (shared with the ALU).
  - Opcode and funct constants, including OP_BNE = 6'h5.
  - A struct for ID/EX controls.
- One combinational sub-module, id_decode: instr → alu_op, operand selects, extend mode, controls. id_ex_ctrl adds the register, the stall/flush priority and the trap logic.

Test Plan:
- Reset check: rst_n=0 for 3 cycles → all outputs 0. Release, then add $3,$1,$2 (0x00221820) with rs=5, rt=7 → next cycle alu_op 0, A=5, B=7, dest 3, reg_write 1.
- Shift operand swap: sll $4,$2,3 (0x000220C0) with rt=0x11 → A=3, B=0x11, alu_op 8. srav $4,$2,$1 with rs=0x24 → A=0x24, alu_op 9.
- Extension modes:
  - addi $5,$0,-1 (0x2005FFFF) → B=0xFFFFFFFF, dest 5, op ADD.
  - andi $5,$0,0xFFFF (0x3005FFFF) → B=0x0000FFFF, op AND.
  - lw $6,-4($1) (0x8C26FFFC) → B=0xFFFFFFFC, mem_read 1, mem_to_reg 1.
- Branch: bne $1,$2,x (0x1422xxxx) → opcode_E 5, alu_op 1, branch_E 1, reg_write 0. With rs=rt=9 the ALU zero output reads 0.
- Hazard controls:
  - Stall 2 cycles with instr_D changing → outputs frozen.
  - Flush together with stall → bubble: valid_E 0, reg_write 0.
  - Write with dest 0, e.g. add $0 → reg_write 0.
- With ID_ILLEGAL_TRAP_EN, load opcode 0x3F → illegal_o 1, illegal_instr_o = 0xFC000000, valid_E 0. A second illegal encoding leaves the captured value unchanged. Reset clears both.
